// File: rtl/icache_assoc_param.sv
// Set-associative, blocking, read-only instruction cache with true-LRU replacement,
// whole-cache flush and saturating hit/miss counters.
module icache_assoc_param #(
   parameter int unsigned NUM_SET    = 8,
   parameter int unsigned NUM_WAY    = 4,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             from_cpu_inst_req_valid,
   input  logic [31:0]      from_cpu_inst_req_addr,
   output logic             to_cpu_inst_req_ready,
   output logic             to_cpu_cache_rsp_valid,
   output logic [31:0]      to_cpu_cache_rsp_data,
   input  logic             from_cpu_cache_rsp_ready,
   output logic             to_mem_rd_req_valid,
   output logic [31:0]      to_mem_rd_req_addr,
   input  logic             from_mem_rd_req_ready,
   input  logic             from_mem_rd_rsp_valid,
   input  logic [31:0]      from_mem_rd_rsp_data,
   input  logic             from_mem_rd_rsp_last,
   output logic             to_mem_rd_rsp_ready,
   input  logic             flush_req,
   output logic             flush_done,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int unsigned IDX_W = $clog2(NUM_SET);
   localparam int unsigned AGE_W = $clog2(NUM_WAY);
   localparam int unsigned WRD_W = $clog2(LINE_WORDS);
   localparam int unsigned OFF_W = WRD_W + 2;
   localparam int unsigned TAG_W = 32 - IDX_W - OFF_W;

   typedef enum logic [2:0] {IDLE, FLUSH, MEM_REQ, RECV, REFILL, RESP} state_t;
   typedef logic [NUM_WAY-1:0][AGE_W-1:0] ages_t;
   typedef ages_t [NUM_SET-1:0] age_arr_t;
   typedef logic [LINE_WORDS-1:0][31:0] line_t;

   function automatic age_arr_t age_init();
      age_arr_t a;
      for (int unsigned s = 0; s < NUM_SET; s++)
         for (int unsigned w = 0; w < NUM_WAY; w++)
            a[s][w] = AGE_W'(w);
      return a;
   endfunction

   localparam age_arr_t AGE_INIT = age_init();

   state_t                           state_q;
   logic [29:0]                      addr_q;
   logic [AGE_W-1:0]                 victim_q;
   logic [WRD_W-1:0]                 beat_q;
   logic [31:0]                      rsp_data_q;
   logic                             rsp_valid_q, mem_req_q, mem_rdy_q, flush_done_q;
   logic [CNT_W-1:0]                 hit_cnt_q, miss_cnt_q;
   logic [NUM_SET-1:0][NUM_WAY-1:0]  valid_q;
   age_arr_t                         age_q;
   logic [TAG_W-1:0]                 tag_q [NUM_SET][NUM_WAY];
   line_t                            data_q [NUM_SET][NUM_WAY];
   line_t                            buf_q;

   logic [TAG_W-1:0] lk_tag, rq_tag;
   logic [IDX_W-1:0] lk_idx, rq_idx;
   logic [WRD_W-1:0] lk_wrd, rq_wrd;
   logic             unused_lsb;

   assign lk_tag     = from_cpu_inst_req_addr[31 -: TAG_W];
   assign lk_idx     = from_cpu_inst_req_addr[OFF_W +: IDX_W];
   assign lk_wrd     = from_cpu_inst_req_addr[2 +: WRD_W];
   assign unused_lsb = ^from_cpu_inst_req_addr[1:0];
   assign rq_tag     = addr_q[29 -: TAG_W];
   assign rq_idx     = addr_q[WRD_W +: IDX_W];
   assign rq_wrd     = addr_q[0 +: WRD_W];

   logic             hit, found_inv;
   logic [AGE_W-1:0] hit_way, victim, target, target_age;
   ages_t            cur_ages, new_ages;

   // Lookup on the live request address; ages are updated for the hit way or the chosen victim.
   always_comb begin
      hit       = 1'b0;
      found_inv = 1'b0;
      hit_way   = '0;
      victim    = '0;
      cur_ages  = age_q[lk_idx];
      new_ages  = cur_ages;
      for (int unsigned w = 0; w < NUM_WAY; w++) begin
         if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
         if (!found_inv && !valid_q[lk_idx][w]) begin
            found_inv = 1'b1;
            victim    = AGE_W'(w);
         end
      end
      if (!found_inv) begin
         for (int unsigned w = 0; w < NUM_WAY; w++)
            if (cur_ages[w] == AGE_W'(NUM_WAY - 1)) victim = AGE_W'(w);
      end
      target     = hit ? hit_way : victim;
      target_age = cur_ages[target];
      for (int unsigned w = 0; w < NUM_WAY; w++) begin
         if (AGE_W'(w) == target)           new_ages[w] = '0;
         else if (cur_ages[w] < target_age) new_ages[w] = cur_ages[w] + 1'b1;
         else                               new_ages[w] = cur_ages[w];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         age_q        <= AGE_INIT;
         addr_q       <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_rdy_q    <= 1'b0;
         flush_done_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         flush_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_req) begin
                  flush_done_q <= 1'b1;
                  state_q      <= FLUSH;
               end else if (from_cpu_inst_req_valid) begin
                  addr_q         <= from_cpu_inst_req_addr[31:2];
                  age_q[lk_idx]  <= new_ages;
                  if (hit) begin
                     if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                     rsp_data_q  <= data_q[lk_idx][hit_way][lk_wrd];
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                     victim_q  <= victim;
                     mem_req_q <= 1'b1;
                     state_q   <= MEM_REQ;
                  end
               end
            end
            FLUSH: begin
               valid_q <= '0;
               age_q   <= AGE_INIT;
               state_q <= IDLE;
            end
            MEM_REQ: begin
               if (from_mem_rd_req_ready) begin
                  mem_req_q <= 1'b0;
                  mem_rdy_q <= 1'b1;
                  beat_q    <= '0;
                  state_q   <= RECV;
               end
            end
            RECV: begin
               if (from_mem_rd_rsp_valid) begin
                  beat_q <= beat_q + 1'b1;
                  if (from_mem_rd_rsp_last) begin
                     mem_rdy_q <= 1'b0;
                     state_q   <= REFILL;
                  end
               end
            end
            REFILL: begin
               valid_q[rq_idx][victim_q] <= 1'b1;
               rsp_data_q  <= buf_q[rq_wrd];
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (from_cpu_cache_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Line buffer and line storage carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (state_q == RECV && from_mem_rd_rsp_valid) buf_q[beat_q] <= from_mem_rd_rsp_data;
      if (state_q == REFILL) begin
         data_q[rq_idx][victim_q] <= buf_q;
         tag_q[rq_idx][victim_q]  <= rq_tag;
      end
   end

   assign to_cpu_inst_req_ready  = (state_q == IDLE) && !flush_req;
   assign to_cpu_cache_rsp_valid = rsp_valid_q;
   assign to_cpu_cache_rsp_data  = rsp_data_q;
   assign to_mem_rd_req_valid    = mem_req_q;
   assign to_mem_rd_req_addr     = {addr_q[29:WRD_W], {OFF_W{1'b0}}};
   assign to_mem_rd_rsp_ready    = mem_rdy_q;
   assign flush_done             = flush_done_q;
   assign hit_cnt                = hit_cnt_q;
   assign miss_cnt               = miss_cnt_q;

endmodule
